// File: rtl/mix_average_nch.sv
// Per-channel frame averager: accumulates a framed sample stream, then divides each
// channel sum by the frame length on one shared restoring divider (truncating toward zero).
module mix_average_nch #(
   parameter int DATA_W = 48,
   parameter int CH     = 2,
   parameter int CNT_W  = 10,
   parameter int FRAC_W = 15
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic [CH*DATA_W-1:0]                     in_data,
   input  logic                                     in_sof,
   input  logic                                     in_eof,
   input  logic                                     in_valid,
   output logic                                     in_ready,
   output logic [CH*(DATA_W+CNT_W+FRAC_W)-1:0]      out_data,
   output logic [CNT_W-1:0]                         out_count,
   output logic                                     out_valid,
   input  logic                                     out_ready,
   output logic                                     err_ovf,
   output logic [1:0]                               fsm_state
);

   // Handshakes: a beat moves on a rising edge where valid and ready are both high;
   // valid never waits on ready, and the sender holds data stable until the beat moves.

   localparam int ACC_W  = DATA_W + CNT_W;
   localparam int OUT_W  = ACC_W + FRAC_W;
   localparam int STEP_W = $clog2(OUT_W + 3);
   localparam int CH_W   = (CH > 1) ? $clog2(CH) : 1;

   localparam logic [CNT_W-1:0]  MAXN       = '1;
   localparam logic [STEP_W-1:0] STEP_LOAD  = '0;
   localparam logic [STEP_W-1:0] STEP_STORE = STEP_W'(OUT_W + 1);
   localparam logic [STEP_W-1:0] STEP_DONE  = STEP_W'(OUT_W + 2);
   localparam logic [CH_W-1:0]   CH_LAST    = CH_W'(CH - 1);

   localparam logic [1:0] S_ACC = 2'd0;
   localparam logic [1:0] S_DIV = 2'd1;
   localparam logic [1:0] S_OUT = 2'd2;

   logic [1:0]        state;
   logic [ACC_W-1:0]  acc [CH];
   logic [ACC_W-1:0]  samp_ext [CH];
   logic [CNT_W-1:0]  cnt;
   logic              inframe;
   logic              ovf;
   logic              beat_ovf;

   logic [STEP_W-1:0] step;
   logic [CH_W-1:0]   ch;
   logic [OUT_W-1:0]  quo;
   logic [CNT_W-1:0]  rem;
   logic              neg;
   logic [CNT_W:0]    rem_sh;
   logic [CNT_W:0]    rem_diff;
   logic              rem_ge;
   logic [ACC_W-1:0]  acc_sel;
   logic [ACC_W-1:0]  acc_mag;
   logic [OUT_W-1:0]  quo_fix;

   for (genvar k = 0; k < CH; k++) begin : g_ext
      assign samp_ext[k] = {{CNT_W{in_data[k*DATA_W + DATA_W - 1]}}, in_data[k*DATA_W +: DATA_W]};
   end

   assign in_ready  = (state == S_ACC);
   assign fsm_state = state;

   // A non-sof beat that would push the count past MAXN marks the frame as overflowed.
   assign beat_ovf = ovf || (cnt == MAXN);

   // Dividend shifts out of quo's MSB while quotient bits shift in at its LSB.
   assign rem_sh   = {rem, quo[OUT_W-1]};
   assign rem_diff = rem_sh - {1'b0, cnt};
   assign rem_ge   = (rem_sh >= {1'b0, cnt});

   assign acc_sel = acc[ch];
   assign acc_mag = acc_sel[ACC_W-1] ? (~acc_sel + ACC_W'(1)) : acc_sel;
   assign quo_fix = neg ? (~quo + OUT_W'(1)) : quo;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_ACC;
         cnt       <= '0;
         inframe   <= 1'b0;
         ovf       <= 1'b0;
         step      <= '0;
         ch        <= '0;
         quo       <= '0;
         rem       <= '0;
         neg       <= 1'b0;
         out_data  <= '0;
         out_count <= '0;
         out_valid <= 1'b0;
         err_ovf   <= 1'b0;
         for (int k = 0; k < CH; k++) acc[k] <= '0;
      end else begin
         err_ovf <= 1'b0;
         case (state)
            S_ACC: begin
               if (in_valid) begin
                  if (in_sof) begin
                     for (int k = 0; k < CH; k++) acc[k] <= samp_ext[k];
                     cnt     <= CNT_W'(1);
                     inframe <= 1'b1;
                     ovf     <= 1'b0;
                     if (in_eof) begin
                        state <= S_DIV;
                        step  <= STEP_LOAD;
                        ch    <= '0;
                     end
                  end else if (inframe) begin
                     if (beat_ovf) begin
                        ovf <= 1'b1;
                     end else begin
                        for (int k = 0; k < CH; k++) acc[k] <= acc[k] + samp_ext[k];
                        cnt <= cnt + CNT_W'(1);
                     end
                     if (in_eof) begin
                        if (beat_ovf) begin
                           err_ovf <= 1'b1;
                           inframe <= 1'b0;
                        end else begin
                           state <= S_DIV;
                           step  <= STEP_LOAD;
                           ch    <= '0;
                        end
                     end
                  end
               end
            end

            S_DIV: begin
               if (step == STEP_LOAD) begin
                  quo  <= {acc_mag, {FRAC_W{1'b0}}};
                  rem  <= '0;
                  neg  <= acc_sel[ACC_W-1];
                  step <= step + STEP_W'(1);
               end else if (step == STEP_STORE) begin
                  out_data[ch*OUT_W +: OUT_W] <= quo_fix;
                  if (ch == CH_LAST) begin
                     step <= STEP_DONE;
                  end else begin
                     ch   <= ch + CH_W'(1);
                     step <= STEP_LOAD;
                  end
               end else if (step == STEP_DONE) begin
                  state     <= S_OUT;
                  out_valid <= 1'b1;
                  out_count <= cnt;
               end else begin
                  rem  <= rem_ge ? rem_diff[CNT_W-1:0] : rem_sh[CNT_W-1:0];
                  quo  <= {quo[OUT_W-2:0], rem_ge};
                  step <= step + STEP_W'(1);
               end
            end

            S_OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  inframe   <= 1'b0;
                  state     <= S_ACC;
               end
            end

            default: state <= S_ACC;
         endcase
      end
   end

endmodule

// File: doc/mix_average_nch.md
MIX_AVERAGE_NCH -- requirements
Module: mix_average_nch

Interface
REQ-001 SHALL have parameter DATA_W, default 48: signed sample width per channel.
REQ-002 SHALL have parameter CH, default 2: number of parallel channels.
REQ-003 SHALL have parameter CNT_W, default 10: frame counter width; maximum frame length MAXN = 2^CNT_W-1.
REQ-004 SHALL have parameter FRAC_W, default 15: fractional bits of the result; derived ACC_W = DATA_W+CNT_W and OUT_W = ACC_W+FRAC_W.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-007 SHALL have port in_data, input, CH*DATA_W: channel k in bits [k*DATA_W +: DATA_W], two's complement.
REQ-008 SHALL have ports in_sof / in_eof, input, 1 each: first and last beat of a frame, qualified by the accept condition.
REQ-009 SHALL have ports in_valid (input, 1) and in_ready (output, 1); a beat is accepted when both are high.
REQ-010 SHALL have port out_data, output, CH*OUT_W: per-channel signed mean, format Q(ACC_W).(FRAC_W).
REQ-011 SHALL have port out_count, output, CNT_W: length of the averaged frame.
REQ-012 SHALL have ports out_valid (output, 1) and out_ready (input, 1).
REQ-013 SHALL have port err_ovf, output, 1: one-cycle pulse when a frame is dropped for exceeding MAXN.

Function
REQ-014 SHALL implement states S_ACC, S_DIV and S_OUT; in_ready = 1 only in S_ACC.
REQ-015 An accepted in_sof beat SHALL load acc[k] = sign-extended sample[k] (to ACC_W), cnt = 1, inframe = 1 and ovf = 0; this applies even mid-frame, discarding the partial frame.
REQ-016 An accepted non-sof beat with inframe = 1 SHALL do acc[k] += sample[k] and cnt += 1; with inframe = 0 it SHALL be discarded with no state change.
REQ-017 A non-sof beat accepted while cnt == MAXN SHALL set ovf = 1 and leave cnt and acc frozen.
REQ-018 An accepted in_eof beat (its sample included) with inframe = 1 and ovf = 0 SHALL move to S_DIV; with ovf = 1 it SHALL pulse err_ovf, clear inframe and stay in S_ACC.
REQ-019 in_sof and in_eof on the same beat SHALL form a 1-sample frame (cnt = 1).
REQ-020 S_DIV SHALL divide channels 0..CH-1 sequentially on one shared restoring divider; no vendor IP.
REQ-021 Each division SHALL be |acc[k]| * 2^FRAC_W / cnt, with the quotient negated when acc[k] < 0, so rounding is toward zero.
REQ-022 Each channel SHALL take exactly ACC_W+FRAC_W+2 cycles: 1 load, ACC_W+FRAC_W iterations, 1 sign-fix/store.
REQ-023 out_valid SHALL rise CH*(ACC_W+FRAC_W+2)+1 cycles after the eof accept edge (151 with the defaults).
REQ-024 In S_OUT, out_data and out_count SHALL hold stable while out_valid = 1 and out_ready = 0.
REQ-025 out_valid && out_ready SHALL return the block to S_ACC with inframe = 0, and out_valid SHALL drop in the next cycle.
REQ-026 in_valid, in_sof and in_eof SHALL be ignored outside S_ACC.

Reset
REQ-027 While rst = 1 the block SHALL be in S_ACC with in_ready = 1, out_valid = 0, err_ovf = 0, out_data = 0, out_count = 0, and acc, cnt, inframe and ovf all 0.
REQ-028 rst asserted mid-frame or mid-division SHALL abort immediately with no out_valid; the first frame after release SHALL be averaged normally.

Verification (defaults: DATA_W=48, CH=2, CNT_W=10, FRAC_W=15)
REQ-029 Four-beat frame, ch0 {10,20,30,41}, ch1 {-3,-3,-3,-2}: out_data ch0 = 827392 (25.25), ch1 = -90112 (-2.75), out_count = 4, out_valid 151 cycles after the eof edge.
REQ-030 Single beat with sof+eof, ch0 = 7, ch1 = -1: ch0 = 229376, ch1 = -32768, out_count = 1.
REQ-031 Frame {-1,0,0} on ch0: ch0 = -10922 (toward zero, not -10923).
REQ-032 1024-beat frame: err_ovf pulses once at eof, no out_valid, in_ready stays 1; the next 2-beat frame averages correctly.
REQ-033 Hold out_ready = 0 for 50 cycles after out_valid: data stable, in_ready = 0, input beats ignored; release gives exactly one handshake.
REQ-034 sof at beat 3 of an open frame, rst pulse during S_DIV, and a non-sof beat with no open frame are each discarded, with the subsequent clean frame correct.
